rom_dump_uart: RTL
==================

# rom_dump_uart

Downstream consumer of a `rom_reader` channel. On a start request it sweeps every ROM address and waits a settle time at each one. It then samples the chip data and streams one ASCII hex line per address over an 8N1 UART. This gives the RomReader board an automatic full-chip dump to a host PC in place of manual button stepping.

## Interface
Parameters:
- `ADDRESS_WIDTH`, default 9: ROM address bits, 1..12. The dump covers 2^ADDRESS_WIDTH addresses.
- `DATA_WIDTH`, default 8: ROM data bits, 1..8. Data is zero-extended to 8 bits before formatting.
- `BAUD_DIVISOR`, default 434: clk cycles per UART bit (50 MHz / 115200). Must be ≥2.
- `SETTLE_CYCLES`, default 16: cycles from an address change to the data sample. Must be ≥1.

Ports:
- `clk` input 1: board clock; all state on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- `start` input 1: dump request, asynchronous level from a board button; a rising edge starts a dump.
- `data_line_in` input DATA_WIDTH: ROM data for the current `address_line`.
- `address_line` output ADDRESS_WIDTH: address currently presented to the ROM.
- `uart_tx` output 1: serial line, idle high.
- `busy` output 1: high while a dump is in progress.
- `done` output 1: one-cycle pulse when a dump completes.

## Operation
- Reset values: `address_line`=0, `uart_tx`=1, `busy`=0, `done`=0, FSM=IDLE, all counters 0.
- `start` passes through a 2-flop synchronizer, then a rising-edge detector on the synchronizer output.
- FSM states:
  - IDLE: `busy`=0. A detected edge sets `address_line`=0 and moves to SETTLE. Edges in any other state are ignored; there is no restart and no queueing.
  - SETTLE: counts SETTLE_CYCLES cycles, then moves to SAMPLE.
  - SAMPLE: one cycle. Latches `data_line_in` into the data register and moves to SEND with character index 0.
  - SEND: transmits 8 characters, index 0..7: addr hex digit [11:8], [7:4], [3:0], 0x20 (space), data hex [7:4], data hex [3:0], 0x0D, 0x0A.
    - The address is zero-extended to 12 bits.
    - Hex digits are uppercase: 0-9 → 0x30-0x39, A-F → 0x41-0x46.
    - After the stop bit of index 7: if `address_line`==2^ADDRESS_WIDTH−1, go to DONE; otherwise increment `address_line` and go to SETTLE.
  - DONE: `done`=1 for this cycle only, `address_line` is set to 0, then the FSM returns to IDLE.
- `busy`=1 in SETTLE, SAMPLE, SEND and DONE.
- UART frame: start bit 0, data bits LSB first, stop bit 1. Each bit is exactly BAUD_DIVISOR cycles, so a frame is 10·BAUD_DIVISOR cycles.
- Characters are sent back-to-back: the next start bit begins on the cycle after the previous stop bit ends.
- `data_line_in` changes after SAMPLE do not affect the current line.
- An asynchronous `reset_n` assertion at any point, including mid-bit, forces the reset values immediately and drops the dump. The next start edge restarts from address 0.

## Timing
- A `start` rising edge, stable across edges, puts the FSM in SETTLE on the 3rd clk rising edge after `start` rises. `busy` goes high on that same edge (call it E).
- SAMPLE occurs at edge E+SETTLE_CYCLES.
- `uart_tx` falls for the first start bit at edge E+SETTLE_CYCLES+1.
- Per-line period: SETTLE_CYCLES + 1 + 80·BAUD_DIVISOR cycles.
- `address_line` changes on the edge immediately after the last stop bit of a line ends.
- Full dump length: 2^ADDRESS_WIDTH × line period, plus 1 DONE cycle.
- `uart_tx`, `busy`, `done` and `address_line` are all registered outputs.

## Test plan
Bench parameters: ADDRESS_WIDTH=2, DATA_WIDTH=4, BAUD_DIVISOR=4, SETTLE_CYCLES=2.

1. Reset: hold `reset_n`=0 with `start` toggling → `uart_tx`=1, `busy`=0, `done`=0, `address_line`=0 throughout.
2. Full dump: ROM model returns data = ~addr (4 bits). Pulse `start` → the decoded UART bytes are exactly "000 0F\r\n001 0E\r\n002 0D\r\n003 0C\r\n".
   - Each line is 323 cycles; `done` pulses once, 1292 cycles after E.
   - `busy` falls on the cycle after `done`, and `address_line` ends at 0.
3. Frame timing: measured from E, `uart_tx` goes low at E+3. Every bit lasts exactly 4 cycles, with no idle gap between characters.
4. Start while busy: pulse `start` again mid-dump, and separately hold it high across the end of a dump → no restart; exactly 4 lines and 1 `done` pulse.
5. Reset mid-character: assert `reset_n`=0 during a data bit of line 1 → `uart_tx`=1 and `busy`=0 without waiting for a clock edge. A subsequent `start` produces output beginning "000 0F".
6. Formatting and sampling: with DATA_WIDTH=8 and the ROM returning 0xAB, then changing to 0x12 one cycle after SAMPLE → data characters are 0x41, 0x42 ('A', 'B').

Source files
------------

// File: rtl/rom_dump_uart.sv
// Sweeps every ROM address, samples data after a settle time, and streams "AAA DD\r\n" per address over 8N1 UART.
// Latency: first start bit SETTLE_CYCLES+1 cycles after busy rises; no backpressure, and start edges are ignored while busy.
module rom_dump_uart #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 8,
    parameter int BAUD_DIVISOR  = 434,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [DATA_WIDTH-1:0]    data_line_in,
    output logic [ADDRESS_WIDTH-1:0] address_line,
    output logic                     uart_tx,
    output logic                     busy,
    output logic                     done
);

    localparam int BW = (BAUD_DIVISOR > 1) ? $clog2(BAUD_DIVISOR) : 1;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, SEND, DONE} state_t;

    state_t                   state_q;
    logic                     start_s1_q, start_s2_q, start_s3_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [7:0]               data_q;
    logic [SW-1:0]            settle_q;
    logic [BW-1:0]            baud_q;
    logic [3:0]               bit_q;
    logic [2:0]               char_q;
    logic                     tx_q, busy_q, done_q;

    logic                     start_edge;
    logic [11:0]              addr12;
    logic [7:0]               char_d;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign start_edge = start_s2_q & ~start_s3_q;
    assign addr12     = 12'(addr_q);

    always_comb begin
        char_d = 8'h20;
        case (char_q)
            3'd0:    char_d = hex_ascii(addr12[11:8]);
            3'd1:    char_d = hex_ascii(addr12[7:4]);
            3'd2:    char_d = hex_ascii(addr12[3:0]);
            3'd3:    char_d = 8'h20;
            3'd4:    char_d = hex_ascii(data_q[7:4]);
            3'd5:    char_d = hex_ascii(data_q[3:0]);
            3'd6:    char_d = 8'h0D;
            3'd7:    char_d = 8'h0A;
            default: char_d = 8'h20;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            start_s1_q <= 1'b0;
            start_s2_q <= 1'b0;
            start_s3_q <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            settle_q   <= '0;
            baud_q     <= '0;
            bit_q      <= '0;
            char_q     <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            start_s1_q <= start;
            start_s2_q <= start_s1_q;
            start_s3_q <= start_s2_q;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_edge) begin
                        addr_q   <= '0;
                        settle_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                        state_q <= SAMPLE;
                    end else begin
                        settle_q <= settle_q + SW'(1);
                    end
                end
                SAMPLE: begin
                    data_q  <= 8'(data_line_in);
                    tx_q    <= 1'b0;
                    baud_q  <= '0;
                    bit_q   <= '0;
                    char_q  <= '0;
                    state_q <= SEND;
                end
                SEND: begin
                    if (baud_q == BW'(BAUD_DIVISOR - 1)) begin
                        baud_q <= '0;
                        if (bit_q == 4'd9) begin
                            if (char_q == 3'd7) begin
                                settle_q <= '0;
                                if (addr_q == LAST_ADDR) begin
                                    addr_q  <= '0;
                                    done_q  <= 1'b1;
                                    state_q <= DONE;
                                end else begin
                                    addr_q  <= addr_q + ADDRESS_WIDTH'(1);
                                    state_q <= SETTLE;
                                end
                            end else begin
                                // Next start bit follows the stop bit with no idle gap.
                                char_q <= char_q + 3'd1;
                                bit_q  <= '0;
                                tx_q   <= 1'b0;
                            end
                        end else begin
                            bit_q <= bit_q + 4'd1;
                            tx_q  <= (bit_q == 4'd8) ? 1'b1 : char_d[bit_q[2:0]];
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign address_line = addr_q;
    assign uart_tx      = tx_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule
